// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared pipeline definitions for branch resolution: recovery FSM encoding and predictor constants.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package branch_resolve_ctrl_pkg;

    // Recovery sequence: IDLE -> FLUSH (one pulse cycle) -> REFILL -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } rec_state_t;

    // Every predictor counter starts as weakly not-taken
    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Saturating 2-bit counter step toward the resolved direction
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == 2'b11) ? cur : cur + 2'b01;
        end
        return (cur == 2'b00) ? cur : cur - 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// EX-stage resolve bus into the branch controller and its redirect/flush controls back to the pipe.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; the stall is a separate scalar input of the controller.
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_cond;
    logic            ex_jump;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] ex_pc_plus4;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_ifid;
    logic            flush_idex;
    logic            busy;

    // Pipeline side: presents resolved instructions, consumes recovery controls
    modport master (
        output ex_valid, ex_is_cond, ex_jump, ex_pred_taken, ex_pc, ex_target, ex_pc_plus4,
        input  redirect, redirect_pc, flush_ifid, flush_idex, busy
    );

    // Controller side
    modport slave (
        input  ex_valid, ex_is_cond, ex_jump, ex_pred_taken, ex_pc, ex_target, ex_pc_plus4,
        output redirect, redirect_pc, flush_ifid, flush_idex, busy
    );
endinterface

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// Branch history table of 2-bit saturating counters indexed by pc word bits.
// Latency: lookup is combinational; update lands on the next rising edge (same-cycle lookup sees old value).
// Backpressure: none; the update port is accepted whenever upd_en is high.
module bht_2bit
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);
    localparam int IDXW = $clog2(ENTRIES);

    logic [1:0]      ctr [ENTRIES];
    logic [IDXW-1:0] lookup_idx;
    logic [IDXW-1:0] upd_idx;
    logic            unused_pc_bits;

    // Word-aligned index: the two byte-offset bits are skipped
    assign lookup_idx     = lookup_pc[IDXW+1:2];
    assign upd_idx        = upd_pc[IDXW+1:2];
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDXW+2], lookup_pc[1:0],
                              upd_pc[XLEN-1:IDXW+2], upd_pc[1:0]};

    // Prediction is the counter MSB, read from the registered table
    assign lookup_taken = ctr[lookup_idx][1];

    // Reset all counters, otherwise train the addressed counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX control transfers, trains the predictor and sequences mispredict recovery.
// Latency: redirect/flush pulse one cycle after an accepted mispredict; busy for two cycles.
// Backpressure: events are taken only when not stalled and idle; events during recovery are dropped.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 if_pred_taken,
    input  logic                 stall_in,
    output logic [15:0]          mispredict_cnt,
    branch_resolve_ctrl_if.slave bus
);
    rec_state_t      state_q;
    rec_state_t      state_d;
    logic            accept;
    logic            actual;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc_q;
    logic            pulse;
    logic            busy;

    // Event qualification: wrong-path or stalled instructions are never acted on
    assign accept     = bus.ex_valid && !stall_in && (state_q == ST_IDLE);
    assign actual     = bus.ex_is_cond ? bus.ex_jump : 1'b1;
    assign mispredict = accept && (actual != bus.ex_pred_taken);

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .XLEN    (XLEN)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (if_pc),
        .lookup_taken (if_pred_taken),
        .upd_en       (accept && bus.ex_is_cond),
        .upd_pc       (bus.ex_pc),
        .upd_taken    (bus.ex_jump)
    );

    // Recovery state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and recovery outputs; FLUSH/REFILL advance unconditionally
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pulse   = 1'b1;
                busy    = 1'b1;
                state_d = ST_REFILL;
            end
            ST_REFILL: begin
                busy    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the correct-path address and count mispredicts, saturating at the top
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc_q  <= '0;
            mispredict_cnt <= '0;
        end else if (mispredict) begin
            redirect_pc_q  <= actual ? bus.ex_target : bus.ex_pc_plus4;
            if (mispredict_cnt != CNT_MAX) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

    assign bus.redirect    = pulse;
    assign bus.flush_ifid  = pulse;
    assign bus.flush_idex  = pulse;
    assign bus.busy        = busy;
    assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table, hand sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        stall_in;
    logic [15:0] mispredict_cnt;

    branch_resolve_ctrl_if #(.XLEN(32)) bus ();

    branch_resolve_ctrl #(.BHT_ENTRIES(16), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .stall_in       (stall_in),
        .mispredict_cnt (mispredict_cnt),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: recovery is tracked as "cycles of recovery left", counters as plain ints
    int          m_ctr [16];
    int          m_left;
    logic [31:0] m_rpc;
    int          m_cnt;
    bit          model_check;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    task automatic model_edge();
        logic act_dir;
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_left = 0;
            m_rpc  = 0;
            m_cnt  = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.ex_valid && !stall_in) begin
            act_dir = bus.ex_is_cond ? bus.ex_jump : 1'b1;
            if (bus.ex_is_cond) begin
                if (bus.ex_jump) m_ctr[idx_of(bus.ex_pc)] = (m_ctr[idx_of(bus.ex_pc)] < 3) ? m_ctr[idx_of(bus.ex_pc)] + 1 : 3;
                else             m_ctr[idx_of(bus.ex_pc)] = (m_ctr[idx_of(bus.ex_pc)] > 0) ? m_ctr[idx_of(bus.ex_pc)] - 1 : 0;
            end
            if (act_dir != bus.ex_pred_taken) begin
                m_left = 2;
                m_rpc  = act_dir ? bus.ex_target : bus.ex_pc_plus4;
                m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end
    endtask

    // One clock: advance the model on the pre-edge inputs, then sample #1 after the edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        if (model_check) begin
            chk("m_redirect",   {31'd0, bus.redirect},   {31'd0, m_left == 2});
            chk("m_flush_ifid", {31'd0, bus.flush_ifid}, {31'd0, m_left == 2});
            chk("m_flush_idex", {31'd0, bus.flush_idex}, {31'd0, m_left == 2});
            chk("m_busy",       {31'd0, bus.busy},       {31'd0, m_left != 0});
            chk("m_redirect_pc", bus.redirect_pc, m_rpc);
            chk("m_cnt",        {16'd0, mispredict_cnt}, m_cnt);
            chk("m_pred",       {31'd0, if_pred_taken},  {31'd0, m_ctr[idx_of(if_pc)] >= 2});
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic j, input logic p, input logic s,
                         input logic [31:0] pc, input logic [31:0] tgt);
        bus.ex_valid      = v;
        bus.ex_is_cond    = c;
        bus.ex_jump       = j;
        bus.ex_pred_taken = p;
        stall_in          = s;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pc_plus4   = pc + 32'd4;
    endtask

    task automatic check_outs(input string tag, input logic redir, input logic bsy,
                              input logic [31:0] rpc, input int cnt, input logic pred);
        chk({tag, "_redirect"},   {31'd0, bus.redirect},   {31'd0, redir});
        chk({tag, "_flush_ifid"}, {31'd0, bus.flush_ifid}, {31'd0, redir});
        chk({tag, "_flush_idex"}, {31'd0, bus.flush_idex}, {31'd0, redir});
        chk({tag, "_busy"},       {31'd0, bus.busy},       {31'd0, bsy});
        chk({tag, "_rpc"},        bus.redirect_pc,         rpc);
        chk({tag, "_cnt"},        {16'd0, mispredict_cnt}, cnt);
        chk({tag, "_pred"},       {31'd0, if_pred_taken},  {31'd0, pred});
    endtask

    typedef struct {
        logic        v, c, j, p, s;
        logic [31:0] pc, tgt;
        logic        e_redir, e_busy;
        logic [31:0] e_rpc;
        int          e_cnt;
        logic        e_pred;
    } vec_t;

    vec_t vec [10];

    initial begin
        // v c j p s   pc      tgt      redir busy rpc     cnt pred   (if_pc = 0x40)
        vec[0] = '{1,1,1,0,0, 32'h40, 32'h100, 1,1, 32'h100, 1, 1}; // mispredict taken, ctr 01->10
        vec[1] = '{0,0,0,0,0, 32'h40, 32'h100, 0,1, 32'h100, 1, 1}; // REFILL
        vec[2] = '{0,0,0,0,0, 32'h40, 32'h100, 0,0, 32'h100, 1, 1}; // back to IDLE
        vec[3] = '{1,1,1,0,0, 32'h40, 32'h100, 1,1, 32'h100, 2, 1}; // ctr 10->11
        vec[4] = '{1,1,0,1,0, 32'h40, 32'h200, 0,1, 32'h100, 2, 1}; // event in FLUSH ignored
        vec[5] = '{1,1,0,1,0, 32'h40, 32'h200, 0,0, 32'h100, 2, 1}; // event in REFILL ignored
        vec[6] = '{1,1,1,1,0, 32'h40, 32'h300, 0,0, 32'h100, 2, 1}; // correct prediction, ctr saturates
        vec[7] = '{1,1,0,1,0, 32'h40, 32'h300, 1,1, 32'h44,  3, 1}; // not-taken mispredict, ctr 11->10
        vec[8] = '{0,0,0,0,0, 32'h40, 32'h300, 0,1, 32'h44,  3, 1};
        vec[9] = '{0,0,0,0,0, 32'h40, 32'h300, 0,0, 32'h44,  3, 1};

        model_check = 1'b0;
        if_pc = 32'h40;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Reset state
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_outs("reset", 0, 0, 32'h0, 0, 0);

        // Directed vector table
        foreach (vec[i]) begin
            drive(vec[i].v, vec[i].c, vec[i].j, vec[i].p, vec[i].s, vec[i].pc, vec[i].tgt);
            cycle();
            check_outs($sformatf("vec%0d", i), vec[i].e_redir, vec[i].e_busy, vec[i].e_rpc,
                       vec[i].e_cnt, vec[i].e_pred);
        end

        // JAL held under stall: no action until the stall drops; JAL does not train the table
        drive(1, 0, 0, 0, 1, 32'h40, 32'h300);
        cycle();
        check_outs("jal_stall0", 0, 0, 32'h44, 3, 1);
        cycle();
        check_outs("jal_stall1", 0, 0, 32'h44, 3, 1);
        stall_in = 1'b0;
        cycle();
        check_outs("jal_go", 1, 1, 32'h300, 4, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        cycle();
        check_outs("jal_idle", 0, 0, 32'h300, 4, 1);

        // Reset during FLUSH aborts recovery and clears everything
        drive(1, 1, 1, 0, 0, 32'h44, 32'h500);
        cycle();
        if_pc = 32'h44;
        check_outs("pre_rst", 1, 1, 32'h500, 5, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_outs("rst_flush44", 0, 0, 32'h0, 0, 0);
        if_pc = 32'h40;
        #1;
        chk("rst_flush40_pred", {31'd0, if_pred_taken}, 32'd0);
        cycle();
        check_outs("rst_after", 0, 0, 32'h0, 0, 0);

        // Randomized traffic against the model, with aliasing pcs and occasional resets
        model_check = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if_pc = {$urandom_range(0, 63), 2'b00};
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  {$urandom_range(0, 63), 2'b00}, $urandom);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter BHT_ENTRIES, default 16, SHALL set the number of 2-bit predictor counters (power of two).
REQ-003 Parameter XLEN, default 32, SHALL set the address width.
REQ-004 clk  in  1  clock, all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 if_pc  in  XLEN  fetch-stage PC used for prediction lookup.
REQ-007 if_pred_taken  out  1  prediction for if_pc.
REQ-008 ex_valid  in  1  EX stage holds a resolved control-transfer instruction.
REQ-009 ex_is_cond  in  1  EX instruction is B-type; 0 means JAL/JALR.
REQ-010 ex_jump  in  1  branch-comparator taken result for the EX instruction.
REQ-011 ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction.
REQ-012 ex_pc, ex_target, ex_pc_plus4  in  XLEN each  EX instruction PC, taken target and fall-through address.
REQ-013 stall_in  in  1  hazard-unit stall; EX contents are not final.
REQ-014 redirect  out  1  PC-select override pulse.
REQ-015 redirect_pc  out  XLEN  next fetch address while redirect=1.
REQ-016 flush_ifid, flush_idex  out  1 each  pipeline-register flush pulses.
REQ-017 busy  out  1  recovery in progress.
REQ-018 mispredict_cnt  out  16  saturating count of mispredictions.

Function
REQ-019 The index SHALL be pc[log2(BHT_ENTRIES)+1:2].
REQ-020 if_pred_taken SHALL be combinational and equal the MSB of the counter at index(if_pc).
REQ-021 An event SHALL be accepted only when ex_valid=1, stall_in=0 and the state is IDLE.
REQ-022 For an accepted event: actual = ex_is_cond ? ex_jump : 1; mispredict = (actual != ex_pred_taken).
REQ-023 For an accepted event with ex_is_cond=1, the counter at index(ex_pc) SHALL saturating-increment if ex_jump=1, else saturating-decrement (range 0..3).
REQ-024 A same-cycle lookup and update of one index SHALL return the pre-update value.
REQ-025 The FSM SHALL have states IDLE, FLUSH and REFILL.
REQ-026 IDLE->FLUSH SHALL occur on an accepted mispredict; otherwise the FSM stays in IDLE.
REQ-027 On an accepted mispredict, the block SHALL latch redirect_pc = actual ? ex_target : ex_pc_plus4.
REQ-028 In FLUSH, redirect, flush_ifid and flush_idex SHALL be 1 for exactly one cycle (first cycle after detection), regardless of stall_in.
REQ-029 FLUSH->REFILL and REFILL->IDLE SHALL each take one cycle unconditionally.
REQ-030 busy SHALL be 1 in FLUSH and REFILL and 0 in IDLE.
REQ-031 Events in FLUSH or REFILL SHALL be ignored (no update, no count); they are wrong-path.
REQ-032 mispredict_cnt SHALL increment by 1 per accepted mispredict and hold at 0xFFFF.
REQ-033 redirect_pc SHALL hold its last latched value outside FLUSH.
REQ-034 Correctly predicted events SHALL cause no pulse and no state change.

Reset
REQ-035 On rst, the state SHALL become IDLE and every counter SHALL become 2'b01 (weakly not-taken).
REQ-036 On rst: redirect, flush_ifid, flush_idex and busy SHALL be 0; redirect_pc and mispredict_cnt SHALL be 0.
REQ-037 rst asserted in FLUSH or REFILL SHALL abort recovery; outputs are at reset values after that edge.

Structure
REQ-038 The FSM state encoding and the counter reset constant (2'b01) SHALL live in the shared pipeline package.
REQ-039 The predictor table SHALL be one sub-module, bht_2bit (lookup port, update port, reset).
REQ-040 FSM, event qualification and counters SHALL stay in branch_resolve_ctrl.

Verification
REQ-041 After rst, if_pc=0x40 -> if_pred_taken=0; redirect, flush_ifid, flush_idex, busy and mispredict_cnt all 0.
REQ-042 Two accepted taken cond events at ex_pc=0x40 (pred 0) -> counter goes 01->10->11; if_pred_taken=1 at if_pc=0x40; mispredict_cnt=2.
REQ-043 Cond event: ex_pred_taken=0, ex_jump=1, ex_target=0x100 -> next cycle redirect=1, redirect_pc=0x100, both flushes=1; busy=1 for 2 cycles; back to IDLE on the 3rd.
REQ-044 JAL event with ex_pred_taken=0 and stall_in=1 -> no action while stalled; after stall drops -> redirect to ex_target.
REQ-045 Second mispredict presented during REFILL -> ignored; mispredict_cnt unchanged; predictor unchanged.
REQ-046 rst asserted during FLUSH -> IDLE next edge; all outputs 0; counters 01.
